reg_file_mp: RTL

- Parametrised multi-port register file; next generation of the CPU datapath's 2-read/1-write register file.
- Adds configurable width, depth and read-port count, a second write port, and optional write-to-read bypass.
- Adds a hardwired-zero option, synchronous clear, and a registered write-conflict flag.
- Sits between decode (read addresses) and writeback (two retire lanes) in the dual-issue datapath.

---
 rtl/reg_file_pkg.sv | 22 ++
 rtl/reg_file_mp_if.sv | 41 ++++
 rtl/reg_file_read_port.sv | 35 +++
 rtl/reg_file_mp.sv | 82 ++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// ---------------------------------------------------------------------------
// reg_file_pkg : default geometry and writeback lane type for reg_file_mp
// Revision 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

package reg_file_pkg;

  localparam int RF_WIDTH    = 32;
  localparam int RF_DEPTH    = 32;
  localparam int RF_NUM_READ = 2;
  localparam int RF_ADDR_W   = $clog2(RF_DEPTH);

  typedef struct packed {
    logic                 we;
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_WIDTH-1:0]  data;
  } wr_lane_t;

endpackage

`default_nettype wire

// File: rtl/reg_file_mp_if.sv
// ---------------------------------------------------------------------------
// reg_file_mp_if : read/write port bundle of the multi-port register file
// Revision 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface reg_file_mp_if
  import reg_file_pkg::*;
#(
  parameter int WIDTH    = RF_WIDTH,
  parameter int DEPTH    = RF_DEPTH,
  parameter int NUM_READ = RF_NUM_READ
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic [NUM_READ*ADDR_W-1:0] ReadRegister;
  logic [NUM_READ*WIDTH-1:0]  ReadData;
  logic                       RegWrite0;
  logic [ADDR_W-1:0]          WriteRegister0;
  logic [WIDTH-1:0]           WriteData0;
  logic                       RegWrite1;
  logic [ADDR_W-1:0]          WriteRegister1;
  logic [WIDTH-1:0]           WriteData1;
  logic                       WriteConflict;

  modport master (
    output ReadRegister, RegWrite0, WriteRegister0, WriteData0,
           RegWrite1, WriteRegister1, WriteData1,
    input  ReadData, WriteConflict
  );

  modport slave (
    input  ReadRegister, RegWrite0, WriteRegister0, WriteData0,
           RegWrite1, WriteRegister1, WriteData1,
    output ReadData, WriteConflict
  );

endinterface

`default_nettype wire

// File: rtl/reg_file_read_port.sv
// ---------------------------------------------------------------------------
// reg_file_read_port : one combinational read mux with bypass and zero reg
// Revision 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module reg_file_read_port #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  mem [DEPTH],
  input  logic              fwd0,
  input  logic [ADDR_W-1:0] fwd_addr0,
  input  logic [WIDTH-1:0]  fwd_data0,
  input  logic              fwd1,
  input  logic [ADDR_W-1:0] fwd_addr1,
  input  logic [WIDTH-1:0]  fwd_data1,
  output logic [WIDTH-1:0]  data
);

  // Lane 1 is evaluated last so it overrides lane 0; the zero register overrides both.
  always_comb begin
    data = mem[addr];
    if (BYPASS && fwd0 && (addr == fwd_addr0)) data = fwd_data0;
    if (BYPASS && fwd1 && (addr == fwd_addr1)) data = fwd_data1;
    if (ZERO_REG && (addr == '0))              data = '0;
  end

endmodule

`default_nettype wire

// File: rtl/reg_file_mp.sv
// ---------------------------------------------------------------------------
// reg_file_mp : parametrised N-read / 2-write register file with bypass
// Revision 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int WIDTH    = RF_WIDTH,
  parameter int DEPTH    = RF_DEPTH,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int NUM_READ = RF_NUM_READ,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input logic          Clk,
  input logic          ResetN,
  reg_file_mp_if.slave bus
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             r_conflict;
  logic             w_wen0;
  logic             w_wen1;
  logic             w_fwd0;
  logic             w_fwd1;
  logic [WIDTH-1:0] w_rd [NUM_READ];

  // Writes aimed at a hardwired-zero register are treated as if never issued.
  assign w_wen0 = bus.RegWrite0 && !(ZERO_REG && (bus.WriteRegister0 == '0));
  assign w_wen1 = bus.RegWrite1 && !(ZERO_REG && (bus.WriteRegister1 == '0));
  assign w_fwd0 = w_wen0 && ResetN;
  assign w_fwd1 = w_wen1 && ResetN;

  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_conflict <= 1'b0;
    end else begin
      if (w_wen0) r_mem[bus.WriteRegister0] <= bus.WriteData0;
      if (w_wen1) r_mem[bus.WriteRegister1] <= bus.WriteData1;
      r_conflict <= w_wen0 && w_wen1 && (bus.WriteRegister0 == bus.WriteRegister1);
    end
  end

  assign bus.WriteConflict = r_conflict;

  generate
    for (genvar k = 0; k < NUM_READ; k++) begin : g_read_port
      reg_file_read_port #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
      ) u_read_port (
        .addr      (bus.ReadRegister[k*ADDR_W +: ADDR_W]),
        .mem       (r_mem),
        .fwd0      (w_fwd0),
        .fwd_addr0 (bus.WriteRegister0),
        .fwd_data0 (bus.WriteData0),
        .fwd1      (w_fwd1),
        .fwd_addr1 (bus.WriteRegister1),
        .fwd_data1 (bus.WriteData1),
        .data      (w_rd[k])
      );
    end
  endgenerate

  always_comb begin
    bus.ReadData = '0;
    for (int k = 0; k < NUM_READ; k++) begin
      bus.ReadData[k*WIDTH +: WIDTH] = w_rd[k];
    end
  end

endmodule

`default_nettype wire
